meas_gate_ctrl: RTL
===================

# meas_gate_ctrl

Measurement sequencer directly upstream of the BCD `count` chain in the NE555 capacitance meter. It fires the 555 monostable, synchronises its output pulse, and drives the counter chain's `clear_n` and `en` so the chain counts system clocks for exactly the pulse's high time. It then strobes a latch for the display stage, waits a hold period and repeats. A timeout flags a missing or stuck pulse.

## Interface
Parameters:
- `TRIG_CYCLES`, 8: width of the `trig_n` low pulse, in clocks (≥1).
- `HOLD_CYCLES`, 12_500_000: idle time between measurements (0.5 s at 25 MHz), ≥1.
- `TIMEOUT_CYCLES`, 50_000_000: maximum clocks spent waiting for the pulse or inside the gate, ≥2.
- `TMR_W`, 32: internal timer width; must hold the largest of the above.

Ports:
- `clk`, in, 1: system clock (25 MHz nominal).
- `clear_n`, in, 1: asynchronous active-low reset.
- `run`, in, 1: level; while high, measurements repeat automatically.
- `ne555_q`, in, 1: raw 555 output, asynchronous to `clk`.
- `trig_n`, out, 1: 555 trigger, active low.
- `cnt_clear_n`, out, 1: to counter chain `clear_n`, active low.
- `cnt_en`, out, 1: to counter chain `en`.
- `latch`, out, 1: one-clock strobe; counter outputs are valid and stable.
- `timeout`, out, 1: sticky per measurement; set when the gate was aborted. Valid with `latch`.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- States: IDLE, CLR, TRIG, WAIT_HI, GATE, LATCH, HOLD.
- IDLE: if `run`=1, go to CLR.
- CLR (1 clock): `cnt_clear_n`=0 and `timeout` cleared. Go to TRIG.
- TRIG: `trig_n`=0 for `TRIG_CYCLES` clocks, then go to WAIT_HI with the timer reset.
  - If the synchronised pulse `s_q` rises during TRIG, enter GATE right after TRIG ends.
- WAIT_HI: when `s_q`=1, go to GATE. If the timer reaches `TIMEOUT_CYCLES`, set `timeout` and go to LATCH.
- GATE: `cnt_en`=1 in every GATE cycle.
  - When `s_q`=0, go to LATCH. No `cnt_en` is asserted in that exit cycle.
  - If the timer reaches `TIMEOUT_CYCLES`, set `timeout` and go to LATCH.
- LATCH (1 clock): `latch`=1. Go to HOLD.
- HOLD: wait `HOLD_CYCLES`. Then go to CLR if `run`=1, otherwise IDLE.
- `run` falling mid-cycle does not abort; the current measurement completes to LATCH/HOLD.
- Timer: `TMR_W` bits, reset on every state entry, saturating (never wraps).

## Timing
- Reset values: `trig_n`=1, `cnt_clear_n`=1, `cnt_en`=0, `latch`=0, `timeout`=0, `busy`=0. State is IDLE and synchronisers are 0.
- All outputs are registered. A reset assertion mid-measurement forces the reset values immediately.
- Synchroniser latency: 2 clocks from `ne555_q` to `s_q`.
- Count accuracy: the number of `cnt_en` cycles equals the number of cycles `s_q` is high, ±0.
- `latch` follows the last `cnt_en` cycle by exactly 2 clocks.
- `busy` rises 1 clock after `run` is sampled high in IDLE.

## Configuration
- `MEAS_GATE_FILTER_EN` defined: after the 2-flop synchroniser, a level change on `s_q` is accepted only after 3 consecutive equal samples.
  - Adds 2 clocks of latency on both edges.
  - Any pulse of 2 clocks or fewer is ignored.
- Undefined: `s_q` is the plain 2-flop synchroniser output.

## Structure
- Package `meas_pkg` holds:
  - the state enum `meas_state_t`;
  - the default constants for `TRIG_CYCLES`, `HOLD_CYCLES`, `TIMEOUT_CYCLES` and `TMR_W`.
- Sub-module `pulse_sync` holds the synchroniser and the filter gated by `MEAS_GATE_FILTER_EN`: in `clk`, `clear_n`, `d`; out `q`.
- The FSM and timer live in `meas_gate_ctrl`.

## Test plan
- **Normal pulse:** reset, `run`=1, `ne555_q` high for 1000 ns (25 clocks), starting 200 ns after `trig_n` falls → exactly 25 `cnt_en` cycles, one `latch` pulse, `timeout`=0.
- **No pulse:** `run`=1, `ne555_q` held 0 with `TIMEOUT_CYCLES`=100 → `latch` 100 clocks after WAIT_HI entry, `timeout`=1, 0 `cnt_en` cycles.
- **Stuck high:** `ne555_q` stuck at 1 with `TIMEOUT_CYCLES`=100 → 100 `cnt_en` cycles, then `latch` with `timeout`=1.
- **Glitch rejection:** with `MEAS_GATE_FILTER_EN`, a 2-clock glitch during WAIT_HI → no GATE entry. Without the macro → 2 `cnt_en` cycles.
- **Reset mid-gate:** assert `clear_n` low during GATE → all outputs take their reset values immediately. After release, IDLE; a new cycle starts with CLR.
- **Run drop:** `run` falls during GATE → the measurement completes with `latch`, then HOLD, then IDLE, with `busy`=0 afterwards.

Source files
------------

// File: rtl/meas_pkg.sv
// meas_pkg: shared state encoding and default timing constants for the
// NE555 capacitance-meter measurement sequencer.
package meas_pkg;

  // Sequencer states; explicit encodings keep waveforms stable across builds.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLR     = 3'd1,
    ST_TRIG    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_GATE    = 3'd4,
    ST_LATCH   = 3'd5,
    ST_HOLD    = 3'd6
  } meas_state_t;

  // Defaults assume a 25 MHz system clock.
  localparam int unsigned TRIG_CYCLES_DEF    = 32'd8;
  localparam int unsigned HOLD_CYCLES_DEF    = 32'd12_500_000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd50_000_000;
  localparam int unsigned TMR_W_DEF          = 32'd32;

endpackage

// File: rtl/meas_gate_ctrl_pulse_sync.sv
// pulse_sync: brings the raw 555 output into the clk domain.
// Optional macro MEAS_GATE_FILTER_EN: after the 2-flop synchroniser a level
// change is only accepted once three consecutive synchronised samples agree,
// which rejects pulses of two clocks or fewer and delays both edges by 2 clocks.
module pulse_sync (
  input  logic clk,
  input  logic clear_n,
  input  logic d,
  output logic q
);

  logic sync1_r;
  logic sync2_r;

  // Two-flop synchroniser for the asynchronous 555 output.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= d;
      sync2_r <= sync1_r;
    end
  end

`ifdef MEAS_GATE_FILTER_EN
  logic hist1_r;
  logic hist2_r;
  logic held_r;

  // Sample history and last accepted level for the glitch filter.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      hist1_r <= 1'b0;
      hist2_r <= 1'b0;
      held_r  <= 1'b0;
    end else begin
      hist1_r <= sync2_r;
      hist2_r <= hist1_r;
      held_r  <= q;
    end
  end

  // Follow the synchronised level only when the last three samples agree.
  always_comb begin
    if ((sync2_r == hist1_r) && (hist1_r == hist2_r)) begin
      q = sync2_r;
    end else begin
      q = held_r;
    end
  end
`else
  assign q = sync2_r;
`endif

endmodule

// File: rtl/meas_gate_ctrl.sv
// meas_gate_ctrl: fires the 555 monostable, gates the BCD counter chain for
// exactly the synchronised pulse high time, strobes a latch, holds, repeats.
// Optional macro MEAS_GATE_FILTER_EN enables the glitch filter in pulse_sync.
module meas_gate_ctrl
  import meas_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TMR_W          = TMR_W_DEF
) (
  input  logic clk,
  input  logic clear_n,
  input  logic run,
  input  logic ne555_q,
  output logic trig_n,
  output logic cnt_clear_n,
  output logic cnt_en,
  output logic latch,
  output logic timeout,
  output logic busy
);

  // Timer values seen in the last cycle of each timed state.
  localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [TMR_W-1:0] TMR_MAX   = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};

  meas_state_t      state_r;
  meas_state_t      state_nxt_s;
  logic [TMR_W-1:0] timer_r;
  logic             s_q_s;
  logic             cnt_en_nxt_s;
  logic             timeout_nxt_s;

  pulse_sync u_sync (
    .clk     (clk),
    .clear_n (clear_n),
    .d       (ne555_q),
    .q       (s_q_s)
  );

  // Next-state logic. cnt_en for a cycle is decided from s_q sampled at the
  // preceding edge, so every high sample of s_q yields exactly one enabled
  // cycle; GATE then spends one extra cycle with cnt_en low before LATCH.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_en_nxt_s  = 1'b0;
    timeout_nxt_s = timeout;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_nxt_s = ST_CLR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLR: begin
        state_nxt_s   = ST_TRIG;
        timeout_nxt_s = 1'b0;
      end
      ST_TRIG: begin
        if (timer_r == TRIG_LAST) begin
          if (s_q_s) begin
            state_nxt_s  = ST_GATE;
            cnt_en_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT_HI;
          end
        end else begin
          state_nxt_s = ST_TRIG;
        end
      end
      ST_WAIT_HI: begin
        if (s_q_s) begin
          state_nxt_s  = ST_GATE;
          cnt_en_nxt_s = 1'b1;
        end else if (timer_r == TMO_LAST) begin
          state_nxt_s   = ST_LATCH;
          timeout_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_HI;
        end
      end
      ST_GATE: begin
        if (!cnt_en) begin
          state_nxt_s = ST_LATCH;
        end else if (timer_r == TMO_LAST) begin
          state_nxt_s   = ST_LATCH;
          timeout_nxt_s = 1'b1;
        end else begin
          state_nxt_s  = ST_GATE;
          cnt_en_nxt_s = s_q_s;
        end
      end
      ST_LATCH: begin
        state_nxt_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (timer_r == HOLD_LAST) begin
          state_nxt_s = run ? ST_CLR : ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and saturating timer that restarts on every state entry.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r <= ST_IDLE;
      timer_r <= {TMR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) begin
        timer_r <= {TMR_W{1'b0}};
      end else if (timer_r != TMR_MAX) begin
        timer_r <= timer_r + TMR_ONE;
      end else begin
        timer_r <= timer_r;
      end
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      trig_n      <= 1'b1;
      cnt_clear_n <= 1'b1;
      cnt_en      <= 1'b0;
      latch       <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      trig_n      <= (state_nxt_s != ST_TRIG);
      cnt_clear_n <= (state_nxt_s != ST_CLR);
      cnt_en      <= cnt_en_nxt_s;
      latch       <= (state_nxt_s == ST_LATCH);
      timeout     <= timeout_nxt_s;
      busy        <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule
